// File: rtl/mem_access_ctrl.sv
// MEM-stage data-RAM request/response sequencer with registered read word.
// Define MEM_ALIGN_CHECK_EN to trap misaligned word/halfword accesses.
module mem_access_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_current_stage,
  input  logic                    mem_read_flag,
  input  logic                    mem_write_flag,
  input  logic [DATA_WIDTH/8-1:0] mem_sel,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_write_data,
  output logic                    ram_en,
  output logic [DATA_WIDTH/8-1:0] ram_write_en,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_write_data,
  input  logic                    ram_addr_ok,
  input  logic                    ram_data_ok,
  input  logic [DATA_WIDTH-1:0]   ram_read_data,
  output logic [DATA_WIDTH-1:0]   ram_read_data_out,
  output logic                    stall_request,
  output logic                    addr_error
);

  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic w_pending;
  logic w_err;
  logic w_issue;
  logic w_req;
  logic w_wait;

  assign w_pending = mem_read_flag | mem_write_flag;

`ifdef MEM_ALIGN_CHECK_EN
  logic w_full;
  logic w_half;
  logic w_mis;

  assign w_full = (mem_sel == {SW{1'b1}});
  assign w_half = (mem_sel == SW'(4'b0011)) |
                  (mem_sel == SW'(4'b1100));
  assign w_mis  = (w_full & (mem_addr[1:0] != 2'b00)) |
                  (w_half & mem_addr[0]);
  assign w_err  = rst & w_pending & w_mis;
`else
  logic w_unused_lo;

  assign w_unused_lo = &{1'b0, mem_addr[1:0]};
  assign w_err       = 1'b0;
`endif

  assign w_req   = (r_state == S_REQ);
  assign w_wait  = (r_state == S_WAIT);
  assign w_issue = (r_state == S_IDLE) & w_pending & ~w_err;

  // Request fields follow the MEM inputs, which the stall keeps stable.
  assign ram_en         = rst & (w_issue | w_req);
  assign ram_write_en   = (ram_en & mem_write_flag) ? mem_sel : '0;
  assign ram_addr       = {mem_addr[ADDR_WIDTH-1:2], 2'b00};
  assign ram_write_data = mem_write_data;

  assign stall_request     = rst & (w_issue | w_req | w_wait);
  assign addr_error        = w_err;
  assign ram_read_data_out = r_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_rdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_state <= ram_addr_ok ? S_WAIT : S_REQ;
          end
        end
        S_REQ: begin
          if (ram_addr_ok) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ram_data_ok) begin
            r_rdata <= ram_read_data;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!stall_current_stage) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus random traffic
// checked every cycle against a transaction-level model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_current_stage;
  logic        mem_read_flag;
  logic        mem_write_flag;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic        ram_addr_ok;
  logic        ram_data_ok;
  logic [31:0] ram_read_data;
  logic [31:0] ram_read_data_out;
  logic        stall_request;
  logic        addr_error;

  int n_vec = 0;
  int n_err = 0;

  mem_access_ctrl #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall_current_stage (stall_current_stage),
    .mem_read_flag       (mem_read_flag),
    .mem_write_flag      (mem_write_flag),
    .mem_sel             (mem_sel),
    .mem_addr            (mem_addr),
    .mem_write_data      (mem_write_data),
    .ram_en              (ram_en),
    .ram_write_en        (ram_write_en),
    .ram_addr            (ram_addr),
    .ram_write_data      (ram_write_data),
    .ram_addr_ok         (ram_addr_ok),
    .ram_data_ok         (ram_data_ok),
    .ram_read_data       (ram_read_data),
    .ram_read_data_out   (ram_read_data_out),
    .stall_request       (stall_request),
    .addr_error          (addr_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic bit misaligned(input logic [3:0] s, input logic [31:0] a);
    return (s == 4'hF && a[1:0] != 2'b00) ||
           ((s == 4'h3 || s == 4'hC) && a[0]);
  endfunction

  // Transaction model: a request is either waiting for acceptance,
  // waiting for data, or completed and held until the stage moves on.
  bit          m_busy = 0;
  bit          m_acc  = 0;
  bit          m_done = 0;
  logic [31:0] m_data = '0;
  bit          advance = 1;

  always @(negedge clk) begin
    bit pend, err, issue, e_en, e_stall;
    logic [31:0] e_out;
    pend = mem_read_flag | mem_write_flag;
`ifdef MEM_ALIGN_CHECK_EN
    err = rst && pend && misaligned(mem_sel, mem_addr);
`else
    err = 1'b0;
`endif
    issue   = rst && pend && !err && !m_busy && !m_done;
    e_en    = issue || (rst && m_busy && !m_acc);
    e_stall = issue || (rst && m_busy);
    e_out   = rst ? m_data : 32'h0;
    chk("m_en", 32'(ram_en), 32'(e_en));
    chk("m_stall", 32'(stall_request), 32'(e_stall));
    chk("m_err", 32'(addr_error), 32'(err));
    chk("m_rdo", ram_read_data_out, e_out);
    chk("m_wdata", ram_write_data, mem_write_data);
    if (e_en) begin
      chk("m_addr", ram_addr, mem_addr & ~32'h3);
      chk("m_we", 32'(ram_write_en),
          mem_write_flag ? 32'(mem_sel) : 32'h0);
    end
    advance = !rst || (!e_stall && !stall_current_stage);
    if (!rst) begin
      m_busy = 0;
      m_acc  = 0;
      m_done = 0;
      m_data = '0;
    end else if (m_done) begin
      m_done = stall_current_stage;
    end else if (m_busy && m_acc) begin
      if (ram_data_ok) begin
        m_data = ram_read_data;
        m_busy = 0;
        m_acc  = 0;
        m_done = 1;
      end
    end else if (e_en) begin
      m_busy = 1;
      if (ram_addr_ok) m_acc = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input bit rd, input bit wr, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] d);
    mem_read_flag  = rd;
    mem_write_flag = wr;
    mem_sel        = s;
    mem_addr       = a;
    mem_write_data = d;
  endtask

  logic [3:0] sels [8] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};

  initial begin
    int en_cnt;
    rst = 1'b0;
    stall_current_stage = 1'b0;
    set_op(0, 0, 4'h0, 32'h0, 32'h0);
    ram_addr_ok   = 1'b0;
    ram_data_ok   = 1'b0;
    ram_read_data = 32'h0;

    // reset state
    repeat (2) begin
      @(negedge clk);
      chk("rst_rdo", ram_read_data_out, 32'h0);
      chk("rst_stall", 32'(stall_request), 32'h0);
      chk("rst_en", 32'(ram_en), 32'h0);
    end

    // fast load
    step();
    rst = 1'b1;
    set_op(1, 0, 4'hF, 32'h100, 32'h0);
    ram_addr_ok = 1'b1;
    @(negedge clk);
    chk("ld_c0_stall", 32'(stall_request), 32'h1);
    chk("ld_c0_en", 32'(ram_en), 32'h1);
    chk("ld_c0_addr", ram_addr, 32'h100);
    step();
    ram_addr_ok   = 1'b0;
    ram_data_ok   = 1'b1;
    ram_read_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("ld_c1_stall", 32'(stall_request), 32'h1);
    chk("ld_c1_en", 32'(ram_en), 32'h0);
    step();
    ram_data_ok = 1'b0;
    @(negedge clk);
    chk("ld_c2_stall", 32'(stall_request), 32'h0);
    chk("ld_c2_rdo", ram_read_data_out, 32'hDEADBEEF);
    chk("ld_model_pin", m_data, 32'hDEADBEEF);
    step();
    set_op(0, 0, 4'h0, 32'h0, 32'h0);

    // store with addr_ok delayed 3 cycles
    step();
    set_op(0, 1, 4'h8, 32'h203, 32'hAA000000);
    en_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      ram_addr_ok = (k == 3);
      @(negedge clk);
      en_cnt += int'(ram_en);
      chk("st_addr", ram_addr, 32'h200);
      chk("st_we", 32'(ram_write_en), 32'h8);
      chk("st_stall", 32'(stall_request), 32'h1);
      step();
    end
    ram_addr_ok   = 1'b0;
    ram_data_ok   = 1'b1;
    ram_read_data = 32'h11111111;
    @(negedge clk);
    chk("st_wait_en", 32'(ram_en), 32'h0);
    chk("st_wait_stall", 32'(stall_request), 32'h1);
    step();
    ram_data_ok = 1'b0;
    @(negedge clk);
    chk("st_done_stall", 32'(stall_request), 32'h0);
    chk("st_en_cycles", 32'(en_cnt), 32'd4);
    step();
    set_op(0, 0, 4'h0, 32'h0, 32'h0);

    // load, then DONE held by pipeline for 5 cycles
    step();
    set_op(1, 0, 4'hF, 32'h40, 32'h0);
    ram_addr_ok = 1'b1;
    @(negedge clk);
    step();
    ram_addr_ok   = 1'b0;
    ram_data_ok   = 1'b1;
    ram_read_data = 32'hCAFEF00D;
    @(negedge clk);
    step();
    stall_current_stage = 1'b1;
    ram_read_data = 32'h0BADBAD0;
    en_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      en_cnt += int'(ram_en);
      chk("hold_rdo", ram_read_data_out, 32'hCAFEF00D);
      chk("hold_stall", 32'(stall_request), 32'h0);
      step();
    end
    chk("hold_no_reissue", 32'(en_cnt), 32'h0);
    stall_current_stage = 1'b0;
    ram_data_ok = 1'b0;
    @(negedge clk);
    step();
    set_op(0, 0, 4'h0, 32'h0, 32'h0);

    // reset during WAIT, then late data_ok, then spurious data_ok in IDLE
    step();
    set_op(1, 0, 4'hF, 32'h80, 32'h0);
    ram_addr_ok = 1'b1;
    @(negedge clk);
    step();
    ram_addr_ok = 1'b0;
    rst = 1'b0;
    set_op(0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rstw_rdo", ram_read_data_out, 32'h0);
    chk("rstw_stall", 32'(stall_request), 32'h0);
    step();
    rst = 1'b1;
    ram_data_ok   = 1'b1;
    ram_read_data = 32'h12345678;
    @(negedge clk);
    chk("late_dok_stall", 32'(stall_request), 32'h0);
    step();
    ram_read_data = 32'h55555555;
    @(negedge clk);
    chk("late_dok_rdo", ram_read_data_out, 32'h0);
    step();
    @(negedge clk);
    chk("spur_dok_rdo", ram_read_data_out, 32'h0);
    chk("spur_dok_stall", 32'(stall_request), 32'h0);
    step();
    ram_data_ok = 1'b0;

    // misaligned word load
    set_op(1, 0, 4'hF, 32'h102, 32'h0);
    @(negedge clk);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_err", 32'(addr_error), 32'h1);
    chk("mis_en", 32'(ram_en), 32'h0);
    chk("mis_stall", 32'(stall_request), 32'h0);
`else
    chk("mis_err", 32'(addr_error), 32'h0);
    chk("mis_en", 32'(ram_en), 32'h1);
    chk("mis_addr", ram_addr, 32'h100);
`endif
    step();
    set_op(0, 0, 4'h0, 32'h0, 32'h0);
    ram_addr_ok = 1'b1;
    ram_data_ok = 1'b1;
    repeat (4) step();
    ram_addr_ok = 1'b0;
    ram_data_ok = 1'b0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      rst                 = ($urandom % 150) != 0;
      ram_addr_ok         = ($urandom % 3) == 0;
      ram_data_ok         = ($urandom % 3) == 0;
      ram_read_data       = $urandom;
      stall_current_stage = ($urandom % 4) == 0;
      if (advance) begin
        int op;
        op = int'($urandom % 4);
        set_op(op == 1 || op == 3, op == 2 || op == 3,
               sels[$urandom % 8], $urandom, $urandom);
      end
    end
    step();
    rst = 1'b1;
    set_op(0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
